rect_sprite_animator: RTL and testbench
=======================================

Name: rect_sprite_animator

Overview:
- Parametrised successor to the single-line bouncing demo. Draws a filled XDIM x YDIM rectangle into the 160x120 frame buffer, erases it once per animation tick, moves it in X and Y independently, and bounces it off all four screen edges.
- Its pixel stream (vga_x, vga_y, vga_colour, plot) drives vga_adapter directly.
- It is the reusable engine behind the ball and paddle objects in the game.

Parameters:
- XSCREEN, 160, screen width in pixels.
- YSCREEN, 120, screen height in pixels.
- XDIM, 20, object width (1..XSCREEN).
- YDIM, 4, object height (1..YSCREEN).
- XSTEP, 1, pixels moved per tick in X (0 disables X motion).
- YSTEP, 1, pixels moved per tick in Y (0 disables Y motion).
- TICK_DIV, 1048576, clock cycles per animation tick. Use 4 for simulation.
- BG_COLOUR, 3'b000, colour used for erase.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  asynchronous active-low reset.
- go  in  1  level; high = animate, low = stop after the current frame.
- init  in  1  load x0/y0 as the start position; honoured only in IDLE.
- x0  in  8  initial X (left edge).
- y0  in  7  initial Y (top edge).
- colour  in  3  draw colour, sampled every DRAW cycle.
- vga_x  out  8  pixel X to the adapter.
- vga_y  out  7  pixel Y to the adapter.
- vga_colour  out  3  pixel colour to the adapter.
- plot  out  1  write strobe to the adapter.
- obj_x  out  8  current object left edge.
- obj_y  out  7  current object top edge.
- busy  out  1  high in any state except IDLE.
- hit_x  out  1  one-cycle pulse on a left or right edge bounce.
- hit_y  out  1  one-cycle pulse on a top or bottom edge bounce.

Behaviour:
- Reset values (asynchronous, all zero): state=IDLE, obj_x=0, obj_y=0, dir_x=+, dir_y=+, xc=yc=0, tick counter=0, plot=0, busy=0, hit_x=hit_y=0.
- Tick generator: free-running counter 0..TICK_DIV-1, wraps to 0. tick=1 for the single cycle when count==TICK_DIV-1. It runs in every state and is never reloaded.
- Pixel counters xc (0..XDIM-1) and yc (0..YDIM-1):
  - One pixel per cycle. xc increments; at XDIM-1 it wraps to 0 and yc increments.
  - vga_x = obj_x + xc and vga_y = obj_y + yc, both combinational.
  - A full draw or erase pass is exactly XDIM*YDIM consecutive cycles with plot=1 and no gaps.
- States:
  - IDLE: plot=0.
    - If init=1: obj_x <= min(x0, XSCREEN-XDIM), obj_y <= min(y0, YSCREEN-YDIM), dir_x=+, dir_y=+.
    - If go=1 and tick=1: go to DRAW with xc=yc=0. init has priority, so simultaneous init and go loads the position first; DRAW starts on a later tick.
  - DRAW: plot=1, vga_colour=colour. After pixel (XDIM-1, YDIM-1), go to WAIT and clear the counters.
  - WAIT: plot=0; the object stays visible. On tick go to ERASE.
  - ERASE: plot=1, vga_colour=BG_COLOUR, same scan order as DRAW. After the last pixel: go to MOVE if go=1, else IDLE.
  - MOVE: one cycle, plot=0. Update the X axis as follows; the Y axis works identically with YSTEP/YSCREEN/YDIM and hit_y.
    - dir_x=+ and obj_x+XSTEP >= XSCREEN-XDIM: obj_x <= XSCREEN-XDIM, dir_x <= -, hit_x=1.
    - dir_x=- and obj_x <= XSTEP: obj_x <= 0, dir_x <= +, hit_x=1.
    - Otherwise: obj_x +/- XSTEP.
    - Comparisons use 9-bit X / 8-bit Y intermediates so nothing wraps.
    - XSTEP=0 leaves the axis frozen with no hit pulse.
    - Both axes may bounce in the same cycle, in which case hit_x and hit_y pulse together.
    - Then go to DRAW.
- Frame timing:
  - Frame period is one tick interval, provided 2*XDIM*YDIM+1 < TICK_DIV.
  - If a pass overruns a tick, that tick is missed and WAIT waits for the next one. This is not an error.
- go deassertion:
  - During DRAW: DRAW completes, then WAIT, then the next tick's ERASE, then IDLE. The screen is left clean.
  - Position is retained in IDLE; go reasserted later resumes from the same position and direction.
- Reset mid-operation clears all state immediately. Pixels already written stay in the frame buffer; clearing them is the responsibility of the adapter's background reload.
- busy is high exactly when state != IDLE.

Test Plan:
- TICK_DIV=4, XDIM=3, YDIM=2, init with x0=10, y0=5, then go=1 -> the DRAW pass emits 6 plot cycles at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) with colour=SW value, and busy=1.
- Continue running -> ERASE emits the same 6 coordinates with BG_COLOUR; after MOVE, obj_x=11 and obj_y=6, and the next DRAW starts at (11,6).
- init x0=156, y0=117 (clamped to 157/118 max) with XDIM=3, YDIM=2 -> obj_x=156, obj_y=117. The first MOVE gives obj_x=157 and obj_y=118 with hit_x and hit_y pulsing together for one cycle. The next MOVE gives 156/117.
- init x0=200 -> obj_x loads 157 (clamped); no plot with x>159 ever occurs in a 50-frame run.
- go dropped mid-DRAW -> DRAW finishes, one ERASE follows, the block returns to IDLE with plot=0 and busy=0, and obj_x/obj_y are unchanged from the drawn position.
- Resetn pulled low mid-ERASE, asynchronously between clock edges -> plot, busy and obj_x/obj_y all go to 0 immediately. After release the block stays in IDLE until go and a tick.

Source files
------------

// File: rtl/rect_sprite_animator.sv
// Bouncing filled-rectangle sprite engine for a 160x120 frame buffer.
// Draws, waits one tick, erases, moves, and repeats while go is held high.
module rect_sprite_animator #(
    parameter int         XSCREEN   = 160,
    parameter int         YSCREEN   = 120,
    parameter int         XDIM      = 20,
    parameter int         YDIM      = 4,
    parameter int         XSTEP     = 1,
    parameter int         YSTEP     = 1,
    parameter int         TICK_DIV  = 1048576,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       go,
    input  logic       init,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic [7:0] obj_x,
    output logic [6:0] obj_y,
    output logic       busy,
    output logic       hit_x,
    output logic       hit_y
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [7:0] XMAX  = 8'(XSCREEN - XDIM);
    localparam logic [6:0] YMAX  = 7'(YSCREEN - YDIM);
    localparam logic [7:0] XLAST = 8'(XDIM - 1);
    localparam logic [6:0] YLAST = 7'(YDIM - 1);

    localparam logic [8:0] XSTEP9 = 9'(XSTEP);
    localparam logic [7:0] YSTEP8 = 8'(YSTEP);
    localparam logic [7:0] XSTEPN = 8'(XSTEP);
    localparam logic [6:0] YSTEPN = 7'(YSTEP);
    localparam bit         X_EN   = (XSTEP != 0);
    localparam bit         Y_EN   = (YSTEP != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAW  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ERASE = 3'd3;
    localparam logic [2:0] S_MOVE  = 3'd4;

    logic [2:0]    r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [7:0]    r_obj_x;
    logic [6:0]    r_obj_y;
    logic          r_dir_x;
    logic          r_dir_y;
    logic [7:0]    r_xc;
    logic [6:0]    r_yc;
    logic          r_hit_x;
    logic          r_hit_y;

    logic          w_tick;
    logic          w_last_px;
    logic [8:0]    w_x_fwd;
    logic [7:0]    w_y_fwd;
    logic          w_x_hi;
    logic          w_x_lo;
    logic          w_y_hi;
    logic          w_y_lo;
    logic [7:0]    w_x_next;
    logic [6:0]    w_y_next;
    logic [7:0]    w_x0_clamp;
    logic [6:0]    w_y0_clamp;

    assign w_tick    = (r_tick_cnt == TICK_LAST);
    assign w_last_px = (r_xc == XLAST) && (r_yc == YLAST);

    // dir = 0 means moving toward larger coordinates
    assign w_x_fwd = {1'b0, r_obj_x} + XSTEP9;
    assign w_y_fwd = {1'b0, r_obj_y} + YSTEP8;
    assign w_x_hi  = X_EN && !r_dir_x && (w_x_fwd >= {1'b0, XMAX});
    assign w_x_lo  = X_EN && r_dir_x && ({1'b0, r_obj_x} <= XSTEP9);
    assign w_y_hi  = Y_EN && !r_dir_y && (w_y_fwd >= {1'b0, YMAX});
    assign w_y_lo  = Y_EN && r_dir_y && ({1'b0, r_obj_y} <= YSTEP8);

    always_comb begin
        w_x_next = r_dir_x ? (r_obj_x - XSTEPN) : (r_obj_x + XSTEPN);
        if (w_x_hi)
            w_x_next = XMAX;
        else if (w_x_lo)
            w_x_next = 8'd0;
    end

    always_comb begin
        w_y_next = r_dir_y ? (r_obj_y - YSTEPN) : (r_obj_y + YSTEPN);
        if (w_y_hi)
            w_y_next = YMAX;
        else if (w_y_lo)
            w_y_next = 7'd0;
    end

    assign w_x0_clamp = (x0 > XMAX) ? XMAX : x0;
    assign w_y0_clamp = (y0 > YMAX) ? YMAX : y0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_obj_x <= 8'd0;
            r_obj_y <= 7'd0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
            r_xc    <= 8'd0;
            r_yc    <= 7'd0;
            r_hit_x <= 1'b0;
            r_hit_y <= 1'b0;
        end else begin
            r_hit_x <= 1'b0;
            r_hit_y <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_xc <= 8'd0;
                    r_yc <= 7'd0;
                    if (init) begin
                        r_obj_x <= w_x0_clamp;
                        r_obj_y <= w_y0_clamp;
                        r_dir_x <= 1'b0;
                        r_dir_y <= 1'b0;
                    end else if (go && w_tick) begin
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW, S_ERASE: begin
                    // scan wraps to 0,0 on the last pixel
                    if (r_xc == XLAST) begin
                        r_xc <= 8'd0;
                        r_yc <= (r_yc == YLAST) ? 7'd0 : r_yc + 7'd1;
                    end else begin
                        r_xc <= r_xc + 8'd1;
                    end
                    if (w_last_px) begin
                        if (r_state == S_DRAW)
                            r_state <= S_WAIT;
                        else
                            r_state <= go ? S_MOVE : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (w_tick)
                        r_state <= S_ERASE;
                end
                S_MOVE: begin
                    r_obj_x <= w_x_next;
                    r_obj_y <= w_y_next;
                    if (w_x_hi || w_x_lo)
                        r_dir_x <= ~r_dir_x;
                    if (w_y_hi || w_y_lo)
                        r_dir_y <= ~r_dir_y;
                    r_hit_x <= w_x_hi || w_x_lo;
                    r_hit_y <= w_y_hi || w_y_lo;
                    r_state <= S_DRAW;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vga_x      = r_obj_x + r_xc;
    assign vga_y      = r_obj_y + r_yc;
    assign plot       = (r_state == S_DRAW) || (r_state == S_ERASE);
    assign vga_colour = (r_state == S_ERASE) ? BG_COLOUR : colour;
    assign obj_x      = r_obj_x;
    assign obj_y      = r_obj_y;
    assign busy       = (r_state != S_IDLE);
    assign hit_x      = r_hit_x;
    assign hit_y      = r_hit_y;

endmodule

// File: tb/tb_rect_sprite_animator.sv
// Directed bench for rect_sprite_animator with a 3x2 sprite and TICK_DIV=4.
// Expected pixels, positions and bounce pulses are hand-derived constants.
module tb_rect_sprite_animator;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       go;
    logic       init;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic       busy;
    logic       hit_x;
    logic       hit_y;

    int n_chk = 0;
    int n_bad = 0;
    int cnt;
    int edges;
    int badpix;
    logic prev;

    always #5 Clock = ~Clock;

    rect_sprite_animator #(
        .XDIM     (3),
        .YDIM     (2),
        .TICK_DIV (4)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .go         (go),
        .init       (init),
        .x0         (x0),
        .y0         (y0),
        .colour     (colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .busy       (busy),
        .hit_x      (hit_x),
        .hit_y      (hit_y)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_plot(input string tag);
        int n;
        n = 0;
        while (!plot && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check(tag, 32'(plot), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // {busy,plot,colour,x,y} for each of the 6 pixels in scan order
    task automatic pass_chk(input string tag, input int bx, input int by,
                            input logic [2:0] col);
        logic [19:0] e;
        wait_plot(tag);
        for (int i = 0; i < 6; i++) begin
            e = {1'b1, 1'b1, col, 8'(bx + i % 3), 7'(by + i / 3)};
            check(tag, 32'({busy, plot, vga_colour, vga_x, vga_y}), 32'(e));
            @(negedge Clock);
        end
    endtask

    initial begin
        Resetn = 1'b0;
        go     = 1'b0;
        init   = 1'b0;
        x0     = 8'd0;
        y0     = 7'd0;
        colour = 3'd5;
        repeat (3) @(negedge Clock);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_obj", 32'({obj_x, obj_y}), 32'd0);
        check("rst_hit", 32'({hit_x, hit_y}), 32'd0);
        Resetn = 1'b1;

        @(negedge Clock);
        init = 1'b1;
        x0   = 8'd10;
        y0   = 7'd5;
        @(negedge Clock);
        init = 1'b0;
        check("init_obj", 32'({obj_x, obj_y}), 32'({8'd10, 7'd5}));
        go = 1'b1;
        pass_chk("draw1", 10, 5, 3'd5);
        pass_chk("erase1", 10, 5, 3'd0);
        pass_chk("draw2", 11, 6, 3'd5);
        check("move_obj", 32'({obj_x, obj_y}), 32'({8'd11, 7'd6}));
        pass_chk("erase2", 11, 6, 3'd0);

        wait_plot("draw3");
        @(negedge Clock);
        @(negedge Clock);
        go  = 1'b0;
        cnt = 2;
        for (int c = 0; c < 200 && busy; c++) begin
            if (plot)
                cnt++;
            @(negedge Clock);
        end
        check("stop_plots", 32'(cnt), 32'd12);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_plot", 32'(plot), 32'd0);
        check("stop_obj", 32'({obj_x, obj_y}), 32'({8'd12, 7'd7}));

        init = 1'b1;
        x0   = 8'd156;
        y0   = 7'd117;
        @(negedge Clock);
        init = 1'b0;
        check("corner_obj", 32'({obj_x, obj_y}), 32'({8'd156, 7'd117}));
        go = 1'b1;
        for (int c = 0; c < 200 && obj_x == 8'd156; c++)
            @(negedge Clock);
        check("bounce_obj", 32'({obj_x, obj_y}), 32'({8'd157, 7'd118}));
        check("bounce_hit", 32'({hit_x, hit_y}), 32'd3);
        @(negedge Clock);
        check("hit_pulse", 32'({hit_x, hit_y}), 32'd0);
        for (int c = 0; c < 200 && obj_x == 8'd157; c++)
            @(negedge Clock);
        check("back_obj", 32'({obj_x, obj_y}), 32'({8'd156, 7'd117}));
        check("back_hit", 32'({hit_x, hit_y}), 32'd0);

        go = 1'b0;
        wait_idle("idle2");
        init = 1'b1;
        x0   = 8'd200;
        y0   = 7'd0;
        @(negedge Clock);
        init = 1'b0;
        check("clamp_obj", 32'({obj_x, obj_y}), 32'({8'd157, 7'd0}));
        go     = 1'b1;
        edges  = 0;
        badpix = 0;
        prev   = 1'b0;
        for (int c = 0; c < 5000 && edges < 100; c++) begin
            @(negedge Clock);
            if (plot && !prev)
                edges++;
            if (plot && (vga_x > 8'd159 || vga_y > 7'd119))
                badpix++;
            prev = plot;
        end
        check("frames", 32'(edges), 32'd100);
        check("offscreen", 32'(badpix), 32'd0);

        cnt = 0;
        while (!(plot && vga_colour == 3'd0) && cnt < 100) begin
            @(negedge Clock);
            cnt++;
        end
        check("find_erase", 32'({plot, vga_colour}), 32'({1'b1, 3'd0}));
        #2 Resetn = 1'b0;
        #1;
        check("arst_out", 32'({plot, busy, obj_x, obj_y}), 32'd0);
        @(negedge Clock);
        go     = 1'b0;
        Resetn = 1'b1;
        repeat (8) @(negedge Clock);
        check("post_idle", 32'({busy, plot}), 32'd0);
        go = 1'b1;
        wait_plot("post_go");
        check("post_px", 32'({busy, vga_colour, vga_x, vga_y}),
              32'({1'b1, 3'd5, 8'd0, 7'd0}));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
